// File: rtl/serial_bcd_tx.sv
// Serialises {op, B, A} LSB-first on ser_en/ser_data after a BCD legality check on every digit.
// Frame starts the cycle after accept; req_ready stays low through the frame and the result-return gap.
module serial_bcd_tx #(
  parameter int DIGITS     = 4,
  parameter int GAP_CYCLES = 22,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [4*DIGITS-1:0] req_a,
  input  logic [4*DIGITS-1:0] req_b,
  input  logic                req_op,
  output logic                ser_en,
  output logic                ser_data,
  output logic                bad_req,
  output logic                busy,
  output logic [CNT_W-1:0]    frames_sent
);

  localparam int FRAME_BITS = 8*DIGITS + 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int GAP_W      = $clog2(GAP_CYCLES);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  typedef struct packed {
    logic                op;
    logic [4*DIGITS-1:0] b;
    logic [4*DIGITS-1:0] a;
  } frame_t;

  state_t                  state;
  logic [FRAME_BITS-1:0]   sreg;
  logic [BIT_W-1:0]        bit_cnt;
  logic [GAP_W-1:0]        gap_cnt;
  frame_t                  load;
  logic                    legal;

  assign load      = '{op: req_op, b: req_b, a: req_a};
  assign req_ready = (state == IDLE);
  // ser_data comes straight off the shift register flop, so it is still a registered output.
  assign ser_data  = sreg[0];

  always_comb begin
    legal = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (req_a[4*d +: 4] > 4'd9 || req_b[4*d +: 4] > 4'd9)
        legal = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sreg        <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      ser_en      <= 1'b0;
      bad_req     <= 1'b0;
      busy        <= 1'b0;
      frames_sent <= '0;
    end else begin
      bad_req <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (legal) begin
              sreg    <= load;
              bit_cnt <= '0;
              ser_en  <= 1'b1;
              busy    <= 1'b1;
              state   <= SHIFT;
            end else begin
              bad_req <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            sreg    <= '0;
            ser_en  <= 1'b0;
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            sreg    <= sreg >> 1;
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        GAP: begin
          // The gap covers the ALU's serial result return before the next frame may start.
          if (gap_cnt == LAST_GAP) begin
            frames_sent <= frames_sent + CNT_W'(1);
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bcd_tx.sv
// Directed bench for serial_bcd_tx: frame contents, rejection, pacing, async reset and counter wrap.
module tb_serial_bcd_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_op;
  logic        ser_en;
  logic        ser_data;
  logic        bad_req;
  logic        busy;
  logic [7:0]  frames_sent;

  int checks   = 0;
  int failures = 0;

  serial_bcd_tx dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .ser_en     (ser_en),
    .ser_data   (ser_data),
    .bad_req    (bad_req),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with req_ready high or after a bounded wait.
  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 64'(req_ready), 64'd1);
  endtask

  task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic op,
                           output logic [32:0] bits, output int len, output logic first_busy);
    wait_ready();
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    bits = '0;
    len  = 0;
    first_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) first_busy = busy;
      if (ser_en) begin
        if (len < 33) bits[len] = ser_data;
        len++;
      end
    end
    wait_ready();
  endtask

  logic [32:0] bits;
  int          len;
  logic        fb;
  logic [7:0]  fs0;
  int          rise[$];
  int          runs[$];
  int          low;
  logic        prev_en;
  int          n;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_en", 64'(ser_en), 64'd0);
    chk("rst_data", 64'(ser_data), 64'd0);
    chk("rst_bad", 64'(bad_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fs", 64'(frames_sent), 64'd0);

    run_frame(16'h1234, 16'h0567, 1'b0, bits, len, fb);
    chk("f1_bits", 64'(bits), 64'h0_0567_1234);
    chk("f1_len", 64'(len), 64'd33);
    chk("f1_busy", 64'(fb), 64'd1);
    chk("f1_fs", 64'(frames_sent), 64'd1);
    chk("f1_idle_busy", 64'(busy), 64'd0);

    run_frame(16'h9999, 16'h0001, 1'b0, bits, len, fb);
    chk("f2_bits", 64'(bits), 64'h0_0001_9999);
    chk("f2_len", 64'(len), 64'd33);
    chk("f2_fs", 64'(frames_sent), 64'd2);

    run_frame(16'h0000, 16'h0000, 1'b0, bits, len, fb);
    chk("zero_bits", 64'(bits), 64'h0);
    chk("zero_len", 64'(len), 64'd33);

    run_frame(16'h0042, 16'h0017, 1'b1, bits, len, fb);
    chk("sub_bits", 64'(bits), 64'h1_0017_0042);
    chk("sub_fs", 64'(frames_sent), 64'd4);

    // Illegal digit in A, then in B.
    for (int k = 0; k < 2; k++) begin
      req_a = (k == 0) ? 16'h12A4 : 16'h1234;
      req_b = (k == 0) ? 16'h0000 : 16'h000F;
      req_op = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("bad_pulse", 64'(bad_req), 64'd1);
      chk("bad_en", 64'(ser_en), 64'd0);
      chk("bad_ready", 64'(req_ready), 64'd1);
      chk("bad_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("bad_one_cycle", 64'(bad_req), 64'd0);
      chk("bad_fs", 64'(frames_sent), 64'd4);
    end

    // Back-to-back with req_valid held high.
    fs0 = frames_sent;
    req_a = 16'h1111; req_b = 16'h2222; req_op = 1'b0; req_valid = 1'b1;
    low = 0; prev_en = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ser_en && !prev_en) rise.push_back(c);
      prev_en = ser_en;
      if (!req_ready) low++;
      else begin
        if (low > 0) runs.push_back(low);
        low = 0;
      end
    end
    req_valid = 1'b0;
    chk("b2b_rises", 64'(rise.size()), 64'd4);
    if (rise.size() >= 3) begin
      chk("b2b_gap1", 64'(rise[1] - rise[0]), 64'd56);
      chk("b2b_gap2", 64'(rise[2] - rise[1]), 64'd56);
    end
    chk("b2b_runs", 64'(runs.size() >= 2), 64'd1);
    if (runs.size() >= 2) begin
      chk("b2b_low0", 64'(runs[0]), 64'd55);
      chk("b2b_low1", 64'(runs[1]), 64'd55);
    end
    wait_ready();
    chk("b2b_fs", 64'(frames_sent), 64'(fs0 + 8'd4));

    // Reset during frame bit 10 clears outputs without a clock edge.
    req_a = 16'h5555; req_b = 16'h5555; req_op = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid_en_before", 64'(ser_en), 64'd1);
    chk("mid_bit10", 64'(ser_data), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_en_async", 64'(ser_en), 64'd0);
    chk("mid_data_async", 64'(ser_data), 64'd0);
    chk("mid_busy_async", 64'(busy), 64'd0);
    chk("mid_fs_async", 64'(frames_sent), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    run_frame(16'h4321, 16'h8765, 1'b1, bits, len, fb);
    chk("post_rst_bits", 64'(bits), 64'h1_8765_4321);
    chk("post_rst_len", 64'(len), 64'd33);
    chk("post_rst_fs", 64'(frames_sent), 64'd1);

    // Run the counter up to 255, then one more frame wraps it.
    req_a = 16'h0909; req_b = 16'h9090; req_op = 1'b0; req_valid = 1'b1;
    n = 0;
    while (frames_sent != 8'd255 && n < 15000) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    chk("wrap_pre", 64'(frames_sent), 64'd255);
    run_frame(16'h0001, 16'h0002, 1'b0, bits, len, fb);
    chk("wrap_bits", 64'(bits), 64'h0_0002_0001);
    chk("wrap_fs", 64'(frames_sent), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
